// File: rtl/bus_slave_port_if.sv
// ---------------------------------------------------------------------------
// bus_slave_port_if
//
// Serial bus bundle between the arbiter/decoder side (master) and one slave
// endpoint.
//
//   s_sel      master -> slave  decoded select, high for a whole transaction
//   s_rw       master -> slave  1 = write, 0 = read (first selected cycle only)
//   s_bus_in   master -> slave  serial address / write data, LSB first
//   s_bus_out  slave -> master  serial read data, LSB first
//   s_dvalid   slave -> master  s_bus_out carries a valid read bit
//   s_ack      slave -> master  one-cycle acknowledge pulse
//   s_bsy      slave -> master  slave busy (one bit of the slave-busy vector)
// ---------------------------------------------------------------------------
interface bus_slave_port_if;
    logic s_sel;
    logic s_rw;
    logic s_bus_in;
    logic s_bus_out;
    logic s_dvalid;
    logic s_ack;
    logic s_bsy;

    modport master (
        output s_sel,
        output s_rw,
        output s_bus_in,
        input  s_bus_out,
        input  s_dvalid,
        input  s_ack,
        input  s_bsy
    );

    modport slave (
        input  s_sel,
        input  s_rw,
        input  s_bus_in,
        output s_bus_out,
        output s_dvalid,
        output s_ack,
        output s_bsy
    );
endinterface

// File: rtl/bus_slave_port.sv
// ---------------------------------------------------------------------------
// bus_slave_port
//
// Serial slave endpoint with a local byte-wide memory. While selected it
// shifts in ADDR_W address bits (LSB first), acknowledges the address, then
// either shifts in and stores one data byte (write) or waits READ_LAT cycles
// and shifts one byte back out (read). Dropping the select mid-transaction
// aborts back to idle without touching memory.
//
// Parameters
//   ADDR_W     address bits per transaction
//   MEM_DEPTH  bytes of storage, must be 2**ADDR_W
//   READ_LAT   idle cycles between address ack and first read bit (1..15)
//
// Ports
//   clk_i      clock, rising edge
//   rst_n_i    asynchronous active-low reset
//   s_if       serial bus, slave modport (see bus_slave_port_if)
//
// All outputs come straight from flops whose next value is decoded from the
// next state, so they are Moore outputs with no input-to-output path.
// ---------------------------------------------------------------------------

// Protocol invariants on the slave outputs.
module bus_slave_port_chk (
    input logic clk_i,
    input logic rst_n_i,
    input logic ack_i,
    input logic bsy_i,
    input logic dvalid_i,
    input logic bus_out_i
);
    a_ack_single : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        ack_i |=> !ack_i);
    a_ack_busy : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        ack_i |-> bsy_i);
    a_dvalid_busy : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        dvalid_i |-> bsy_i);
    a_out_qualified : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !dvalid_i |-> !bus_out_i);
endmodule

module bus_slave_port #(
    parameter int ADDR_W    = 12,
    parameter int MEM_DEPTH = 4096,
    parameter int READ_LAT  = 2
) (
    input logic             clk_i,
    input logic             rst_n_i,
    bus_slave_port_if.slave s_if
);

    // Counter must reach ADDR_W-1 (address), 7 (data bits) and 14 (latency).
    localparam int CNT_W = ($clog2(ADDR_W) > 4) ? $clog2(ADDR_W) : 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_ACK_A = 3'd2,
        ST_WDATA = 3'd3,
        ST_WACK  = 3'd4,
        ST_RWAIT = 3'd5,
        ST_RDATA = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               rw_q, rw_d;
    logic               mem_we_s;

    logic               ack_s, bsy_s, dvalid_s, bus_out_s;
    logic               ack_q, bsy_q, dvalid_q, bus_out_q;

    logic               sel_s, rw_in_s, bus_in_s;

    logic [7:0]         mem_q [MEM_DEPTH];

    assign sel_s    = s_if.s_sel;
    assign rw_in_s  = s_if.s_rw;
    assign bus_in_s = s_if.s_bus_in;

    // Next-state and datapath update for the transaction sequencer.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        rw_d     = rw_q;
        mem_we_s = 1'b0;

        if (!sel_s && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            // Abort: contents of addr/shift are left as they are.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_s) begin
                        addr_d  = ADDR_W'(bus_in_s);
                        rw_d    = rw_in_s;
                        cnt_d   = CNT_W'(1);
                        state_d = (ADDR_W == 1) ? ST_ACK_A : ST_ADDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_ADDR: begin
                    for (int i = 0; i < ADDR_W; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            addr_d[i] = bus_in_s;
                        end else begin
                            addr_d[i] = addr_q[i];
                        end
                    end
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                        state_d = ST_ACK_A;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_ACK_A: begin
                    cnt_d   = '0;
                    state_d = rw_q ? ST_WDATA : ST_RWAIT;
                end

                ST_WDATA: begin
                    // Shift in from the top so the first bit ends up in bit 0.
                    shift_d = {bus_in_s, shift_q[7:1]};
                    if (cnt_q == CNT_W'(7)) begin
                        mem_we_s = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_WACK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_WACK: begin
                    state_d = ST_DONE;
                end

                ST_RWAIT: begin
                    if (cnt_q == CNT_W'(READ_LAT - 1)) begin
                        shift_d = mem_q[addr_q];
                        cnt_d   = '0;
                        state_d = ST_RDATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_RDATA: begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    // A select held high here never re-triggers.
                    if (!sel_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so the output flops track the state.
    always_comb begin
        ack_s     = 1'b0;
        bsy_s     = 1'b0;
        dvalid_s  = 1'b0;
        bus_out_s = 1'b0;
        case (state_d)
            ST_ADDR:  bsy_s = 1'b1;
            ST_ACK_A: begin
                ack_s = 1'b1;
                bsy_s = 1'b1;
            end
            ST_WDATA: bsy_s = 1'b1;
            ST_WACK:  begin
                ack_s = 1'b1;
                bsy_s = 1'b1;
            end
            ST_RWAIT: bsy_s = 1'b1;
            ST_RDATA: begin
                bsy_s     = 1'b1;
                dvalid_s  = 1'b1;
                bus_out_s = shift_d[0];
            end
            default: begin
                ack_s     = 1'b0;
                bsy_s     = 1'b0;
                dvalid_s  = 1'b0;
                bus_out_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            shift_q   <= 8'h00;
            rw_q      <= 1'b0;
            ack_q     <= 1'b0;
            bsy_q     <= 1'b0;
            dvalid_q  <= 1'b0;
            bus_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            ack_q     <= ack_s;
            bsy_q     <= bsy_s;
            dvalid_q  <= dvalid_s;
            bus_out_q <= bus_out_s;
        end
    end

    // Local storage; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[addr_q] <= shift_d;
        end
    end

    assign s_if.s_ack     = ack_q;
    assign s_if.s_bsy     = bsy_q;
    assign s_if.s_dvalid  = dvalid_q;
    assign s_if.s_bus_out = bus_out_q;

    bus_slave_port_chk u_chk (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .ack_i     (ack_q),
        .bsy_i     (bsy_q),
        .dvalid_i  (dvalid_q),
        .bus_out_i (bus_out_q)
    );

endmodule
